// File: rtl/vga_scan_source_if.sv
// Pixel stream between the upstream producer and the scan source FIFO.
// The producer side is the master, and the scan source side is the slave.
interface vga_scan_source_if;
    logic [23:0] iPix_Data;
    logic        iPix_Valid;
    logic        oPix_Ready;

    modport master (
        output iPix_Data,
        output iPix_Valid,
        input  oPix_Ready
    );

    modport slave (
        input  iPix_Data,
        input  iPix_Valid,
        output oPix_Ready
    );
endinterface

// File: rtl/vga_scan_source.sv
// Scan-timing and pixel-supply block for the VGA output path.
// Free-running H/V counters feed the controller. Pixels arrive over a
// valid/ready stream into a small FIFO. Each controller read request pops one
// pixel, and that pixel appears on the RGB registers one cycle later.
module vga_scan_source #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    vga_scan_source_if.slave   pix,
    output logic [15:0]        oH_Cont,
    output logic [15:0]        oV_Cont,
    output logic               oFrame_Sync,
    input  logic               iREAD_Request,
    output logic [7:0]         oRed,
    output logic [7:0]         oGreen,
    output logic [7:0]         oBlue,
    output logic               oUnderflow,
    output logic [LVL_W-1:0]   oFifo_Level
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [15:0]      H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0]      V_LAST    = 16'(V_TOTAL - 1);

    logic [23:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [LVL_W-1:0] level;
    logic             pushEn;
    logic             popEn;
    logic             emptyNow;

    // Ready and level come only from the registered occupancy. This avoids
    // any combinational path from valid or request to these outputs.
    assign emptyNow       = (level == '0);
    assign pix.oPix_Ready = (level < DEPTH_LVL);
    assign pushEn         = pix.iPix_Valid && pix.oPix_Ready;
    assign popEn          = iREAD_Request && !emptyNow;
    assign oFifo_Level    = level;
    assign oFrame_Sync    = (oH_Cont == '0) && (oV_Cont == '0);

    // Free-running raster counters. The vertical counter steps on each horizontal wrap.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oH_Cont <= '0;
            oV_Cont <= '0;
        end else if (oH_Cont == H_LAST) begin
            oH_Cont <= '0;
            if (oV_Cont == V_LAST) begin
                oV_Cont <= '0;
            end else begin
                oV_Cont <= oV_Cont + 16'd1;
            end
        end else begin
            oH_Cont <= oH_Cont + 16'd1;
        end
    end

    // FIFO storage is not reset. Clearing the pointers and level discards its contents.
    always_ff @(posedge iCLK) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= pix.iPix_Data;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Register the popped word for the controller. This register loads zero on any slot without a pop, and an empty request latches underflow.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            {oRed, oGreen, oBlue} <= '0;
            oUnderflow            <= 1'b0;
        end else begin
            if (popEn) begin
                {oRed, oGreen, oBlue} <= fifoMem[rdPtr];
            end else begin
                {oRed, oGreen, oBlue} <= '0;
            end
            if (iREAD_Request && emptyNow) begin
                oUnderflow <= 1'b1;
            end
        end
    end

endmodule
